lcd_bus_monitor: RTL and testbench
==================================

Name: lcd_bus_monitor

Overview:
- Receiving end of the character-LCD write bus (E/RS/RW/DATA, 8-bit HD44780-style) that the display driver produces.
- Decodes each bus transaction, maintains a 2x16 display buffer, cursor address and display state, and models controller busy time.
- Used as a synthesizable on-board checker and as the reference responder in the bench. Its readback port lets the bench or a debug path compare the displayed clock/stopwatch/alarm text against expectations.

Parameters:
- CLEAR_CYCLES, 2000, clk cycles the block stays busy after Clear Display or Return Home (minimum 32).
- CMD_CYCLES, 40, clk cycles the block stays busy after any other command or data write (minimum 1).

Ports:
- clk  input  1  system clock; the same clock as the LCD driver.
- resetn  input  1  asynchronous active-low reset.
- LCD_E  input  1  enable strobe from the driver.
- LCD_RS  input  1  0 = command, 1 = data.
- LCD_RW  input  1  0 = write, 1 = read.
- LCD_DATA  input  8  bus data.
- rd_addr  input  5  buffer readback index: [4] = row, [3:0] = column.
- rd_data  output  8  character at rd_addr, 1-cycle latency.
- cursor  output  7  current DDRAM address.
- busy  output  1  controller busy model.
- disp_on  output  1  display-on bit (D) from the last Display Control command.
- inc_mode  output  1  I/D bit from Entry Mode; 1 = increment.
- xfer_count  output  16  accepted transactions, saturating at 16'hFFFF.
- err  output  3  sticky errors: [0] transaction while busy, [1] read cycle (RW=1), [2] Function Set with DL=0.

Behaviour:
- Reset (async, resetn=0):
  - buffer contents undefined until the first Clear; rd_data = 0.
  - cursor = 0, busy = 0, disp_on = 0, inc_mode = 1, xfer_count = 0, err = 0.
  - FSM returns to IDLE; a fill in progress is abandoned.
- Strobe detection:
  - LCD_E is registered once.
  - RS, RW and DATA are captured every cycle while LCD_E = 1.
  - A transaction is the cycle where E_q = 1 and LCD_E = 0; it uses the captured values. Minimum E-high width is 1 cycle.
- Acceptance rules at a transaction:
  - If busy = 1: set err[0]; the transaction is dropped.
  - Else if RW = 1: set err[1]; drop.
  - Else accept: increment xfer_count and load the busy counter.
- Command decode (RS=0), priority from MSB:
  - 1xxxxxxx: Set DDRAM address; cursor = DATA[6:0].
  - 001xxxxx: Function Set; if DATA[4] = 0, set err[2]; no other effect.
  - 01xxxxxx: CGRAM address; ignored, but still counted and makes the block busy.
  - 00001DCB: disp_on = D.
  - 000001IS: inc_mode = I; the S bit is ignored.
  - 0000001x: Return Home; cursor = 0; busy CLEAR_CYCLES.
  - 00000001: Clear; enter FILL, write 8'h20 to all 32 buffer locations (one per cycle), cursor = 0, inc_mode = 1; busy CLEAR_CYCLES.
  - 8'h00: ignored; CMD_CYCLES busy.
- Data write (RS=1):
  - If cursor is in 0x00-0x0F, store to row 0 at column cursor[3:0].
  - If cursor is in 0x40-0x4F, store to row 1 at column cursor[3:0].
  - Any other address: no store.
  - Then step the cursor.
- Cursor step:
  - inc: 0x27 -> 0x40, 0x67 -> 0x00, otherwise +1.
  - dec: 0x00 -> 0x67, 0x40 -> 0x27, otherwise -1.
  - A Set DDRAM address outside 0x00-0x27 / 0x40-0x67 is loaded as-is; the next step then continues +1/-1 with 7-bit wrap.
- Busy:
  - Asserted the cycle after an accepted transaction; stays high for the configured count.
  - busy = 1 throughout FILL regardless of count; FILL and the counter run concurrently.
  - busy falls only after both have finished.
- FSM states:
  - IDLE -> EXEC on an accepted transaction.
  - EXEC -> FILL on Clear, otherwise EXEC -> WAIT.
  - FILL (32 cycles) -> WAIT.
  - WAIT -> IDLE when the busy counter reaches 0.
- Readback: rd_data is registered from buffer[rd_addr]. If a read and a write hit the same address in the same cycle, rd_data returns the old value.

Decomposition:
- Package lcd_mon_pkg:
  - command opcode masks/values;
  - row base addresses 7'h00 and 7'h40;
  - line-end addresses 7'h27 and 7'h67;
  - space character 8'h20;
  - FSM state enum;
  - err bit indices.
- Sub-module lcd_ddram_buf: 32x8 buffer, one write port, one registered read port.

Test Plan:
- Reset, then Function Set 8'h38, Display Control 8'h0C, Clear 8'h01, wait for busy to fall -> disp_on = 1, all 32 rd_data = 8'h20, cursor = 0, xfer_count = 3, err = 0.
- Set DDRAM address 8'hC0, then write "12:34:56" -> row 1 columns 0-7 hold ASCII 31 32 3A 33 34 3A 35 36; cursor = 7'h48.
- Cursor at 7'h27 plus one write -> no store, cursor = 7'h40. Entry Mode 8'h04 at cursor 7'h40 plus one write -> char stored at row 1 column 0, cursor = 7'h27.
- Second E strobe 5 cycles after a data write with CMD_CYCLES = 40 -> err[0] = 1, buffer unchanged, xfer_count not incremented. RW = 1 strobe -> err[1] = 1.
- Function Set 8'h28 -> err[2] = 1. Assert resetn low for 1 cycle mid-FILL -> all outputs return to reset values on the same edge, FSM = IDLE.
- Write 16 chars to row 0, then read rd_addr 0-15 -> 1-cycle latency. Write and read the same address in the same cycle -> old data returned, new data on the following read.

Source files
------------

// File: rtl/lcd_mon_pkg.sv
// Purpose : shared constants, FSM encoding and cursor helper for the LCD bus monitor.
// Latency : n/a (package only).
// Backpres: n/a (package only).
package lcd_mon_pkg;

   // Command opcodes: a command matches when (data & MASK) == VAL.
   // They are decoded in priority order from the MSB down.
   localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
   localparam logic [7:0] CMD_DDRAM_VAL  = 8'h80;
   localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
   localparam logic [7:0] CMD_FUNC_VAL   = 8'h20;
   localparam logic [7:0] CMD_CGRAM_MASK = 8'hC0;
   localparam logic [7:0] CMD_CGRAM_VAL  = 8'h40;
   localparam logic [7:0] CMD_DISP_MASK  = 8'hF8;
   localparam logic [7:0] CMD_DISP_VAL   = 8'h08;
   localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
   localparam logic [7:0] CMD_ENTRY_VAL  = 8'h04;
   localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
   localparam logic [7:0] CMD_HOME_VAL   = 8'h02;
   localparam logic [7:0] CMD_CLEAR_MASK = 8'hFF;
   localparam logic [7:0] CMD_CLEAR_VAL  = 8'h01;

   // DDRAM geometry of a 2-line controller.
   localparam logic [6:0] ROW0_BASE = 7'h00;
   localparam logic [6:0] ROW1_BASE = 7'h40;
   localparam logic [6:0] ROW0_END  = 7'h27;
   localparam logic [6:0] ROW1_END  = 7'h67;

   localparam logic [7:0] SPACE_CHAR = 8'h20;
   localparam logic [4:0] FILL_LAST  = 5'd31;

   // Sticky error bit positions.
   localparam int ERR_BUSY = 0;
   localparam int ERR_READ = 1;
   localparam int ERR_DL   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_FILL = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   function automatic logic cmd_is(input logic [7:0] d, input logic [7:0] mask,
                                   input logic [7:0] val);
      return (d & mask) == val;
   endfunction

   // Address after one data write. Line ends hop to the other line; any
   // out-of-range address just moves by one with 7-bit wrap.
   function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic inc);
      logic [6:0] n;
      if (inc) begin
         if (a == ROW0_END)      n = ROW1_BASE;
         else if (a == ROW1_END) n = ROW0_BASE;
         else                    n = a + 7'd1;
      end else begin
         if (a == ROW0_BASE)      n = ROW1_END;
         else if (a == ROW1_BASE) n = ROW0_END;
         else                     n = a - 7'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/lcd_mon_ddram_buf.sv
// Purpose : 32x8 display buffer (2 rows x 16 columns), one write port, one registered read port.
// Latency : read data appears 1 cycle after rd_addr; same-cycle write/read returns old data.
// Backpres: none; both ports accept every cycle.
// Ports   : clk, resetn (async, low) | wr_en/wr_addr/wr_data write port | rd_addr -> rd_data (registered).
module lcd_ddram_buf (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   // Storage is not reset; contents are meaningful only after a Clear.
   logic [7:0] mem_q [0:31];
   logic [7:0] rd_data_q;
   logic [7:0] rd_data_d;

   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Purpose : decodes HD44780-style 8-bit write transactions into a 2x16 buffer, cursor and display state.
// Latency : a transaction takes effect on the edge ending the E-fall cycle; rd_data is 1 cycle behind rd_addr.
// Backpres: none on the bus; a strobe arriving while busy is dropped and flagged in err[0].
// Ports   : clk, resetn | LCD_E/RS/RW/DATA bus in | rd_addr -> rd_data readback |
//           cursor, busy, disp_on, inc_mode, xfer_count, err status out.
module lcd_bus_monitor
   import lcd_mon_pkg::*;
#(
   parameter int CLEAR_CYCLES = 2000,
   parameter int CMD_CYCLES   = 40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        LCD_E,
   input  logic        LCD_RS,
   input  logic        LCD_RW,
   input  logic [7:0]  LCD_DATA,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic [6:0]  cursor,
   output logic        busy,
   output logic        disp_on,
   output logic        inc_mode,
   output logic [15:0] xfer_count,
   output logic [2:0]  err
);

   localparam int CNT_MAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic [7:0]       data_q, data_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       fill_idx_q, fill_idx_d;
   logic             is_clear_q, is_clear_d;
   logic [6:0]       cursor_q, cursor_d;
   logic             disp_on_q, disp_on_d;
   logic             inc_mode_q, inc_mode_d;
   logic [15:0]      xfer_count_q, xfer_count_d;
   logic [2:0]       err_q, err_d;

   logic             xact;
   logic             busy_w;
   logic             buf_we;
   logic [4:0]       buf_waddr;
   logic [7:0]       buf_wdata;

   // A transaction is the falling edge of E, seen one cycle late.
   assign xact = e_q & ~LCD_E;

   // The Clear's EXEC cycle is covered so busy never dips between the
   // counter and the fill; otherwise the counter alone (>= 1 in EXEC) holds it.
   assign busy_w = (cnt_q != '0) || (state_q == ST_FILL) ||
                   ((state_q == ST_EXEC) && is_clear_q);

   always_comb begin
      e_d          = LCD_E;
      rs_d         = LCD_E ? LCD_RS   : rs_q;
      rw_d         = LCD_E ? LCD_RW   : rw_q;
      data_d       = LCD_E ? LCD_DATA : data_q;
      state_d      = state_q;
      cnt_d        = (cnt_q != '0) ? (cnt_q - CNT_ONE) : cnt_q;
      fill_idx_d   = fill_idx_q;
      is_clear_d   = is_clear_q;
      cursor_d     = cursor_q;
      disp_on_d    = disp_on_q;
      inc_mode_d   = inc_mode_q;
      xfer_count_d = xfer_count_q;
      err_d        = err_q;
      buf_we       = 1'b0;
      buf_waddr    = fill_idx_q;
      buf_wdata    = SPACE_CHAR;

      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_EXEC: begin
            fill_idx_d = '0;
            state_d    = is_clear_q ? ST_FILL : ST_WAIT;
         end
         ST_FILL: begin
            buf_we     = 1'b1;
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == FILL_LAST) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Acceptance is only possible with busy low, i.e. in IDLE or a WAIT
      // whose counter has drained, so it never collides with the fill port.
      if (xact) begin
         if (busy_w) begin
            err_d[ERR_BUSY] = 1'b1;
         end else if (rw_q) begin
            err_d[ERR_READ] = 1'b1;
         end else begin
            xfer_count_d = (xfer_count_q == 16'hFFFF) ? xfer_count_q : (xfer_count_q + 16'd1);
            cnt_d        = CMD_LOAD;
            is_clear_d   = 1'b0;
            state_d      = ST_EXEC;
            if (rs_q) begin
               if (cursor_q[6:4] == ROW0_BASE[6:4]) begin
                  buf_we    = 1'b1;
                  buf_waddr = {1'b0, cursor_q[3:0]};
                  buf_wdata = data_q;
               end else if (cursor_q[6:4] == ROW1_BASE[6:4]) begin
                  buf_we    = 1'b1;
                  buf_waddr = {1'b1, cursor_q[3:0]};
                  buf_wdata = data_q;
               end
               cursor_d = cursor_step(cursor_q, inc_mode_q);
            end else if (cmd_is(data_q, CMD_DDRAM_MASK, CMD_DDRAM_VAL)) begin
               cursor_d = data_q[6:0];
            end else if (cmd_is(data_q, CMD_FUNC_MASK, CMD_FUNC_VAL)) begin
               // Only the 8-bit interface is modelled; DL=0 is a driver bug.
               if (!data_q[4]) begin
                  err_d[ERR_DL] = 1'b1;
               end
            end else if (cmd_is(data_q, CMD_CGRAM_MASK, CMD_CGRAM_VAL)) begin
               // CGRAM is not modelled; the command only costs busy time.
               cursor_d = cursor_q;
            end else if (cmd_is(data_q, CMD_DISP_MASK, CMD_DISP_VAL)) begin
               disp_on_d = data_q[2];
            end else if (cmd_is(data_q, CMD_ENTRY_MASK, CMD_ENTRY_VAL)) begin
               inc_mode_d = data_q[1];
            end else if (cmd_is(data_q, CMD_HOME_MASK, CMD_HOME_VAL)) begin
               cursor_d = ROW0_BASE;
               cnt_d    = CLEAR_LOAD;
            end else if (cmd_is(data_q, CMD_CLEAR_MASK, CMD_CLEAR_VAL)) begin
               cursor_d   = ROW0_BASE;
               inc_mode_d = 1'b1;
               cnt_d      = CLEAR_LOAD;
               is_clear_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q          <= 1'b0;
         rs_q         <= 1'b0;
         rw_q         <= 1'b0;
         data_q       <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         fill_idx_q   <= '0;
         is_clear_q   <= 1'b0;
         cursor_q     <= '0;
         disp_on_q    <= 1'b0;
         inc_mode_q   <= 1'b1;
         xfer_count_q <= '0;
         err_q        <= '0;
      end else begin
         e_q          <= e_d;
         rs_q         <= rs_d;
         rw_q         <= rw_d;
         data_q       <= data_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_idx_q   <= fill_idx_d;
         is_clear_q   <= is_clear_d;
         cursor_q     <= cursor_d;
         disp_on_q    <= disp_on_d;
         inc_mode_q   <= inc_mode_d;
         xfer_count_q <= xfer_count_d;
         err_q        <= err_d;
      end
   end

   lcd_ddram_buf u_buf (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (buf_we),
      .wr_addr (buf_waddr),
      .wr_data (buf_wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign cursor     = cursor_q;
   assign busy       = busy_w;
   assign disp_on    = disp_on_q;
   assign inc_mode   = inc_mode_q;
   assign xfer_count = xfer_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Purpose : directed bench for lcd_bus_monitor; expectations queued at issue, checked by a monitor.
// Latency : reads are checked one cycle after rd_addr is presented, status in the cycle requested.
// Backpres: n/a.
module tb_lcd_bus_monitor;

   localparam int SEL_RD   = 0;
   localparam int SEL_CUR  = 1;
   localparam int SEL_DISP = 2;
   localparam int SEL_INC  = 3;
   localparam int SEL_XFER = 4;
   localparam int SEL_ERR  = 5;
   localparam int SEL_BUSY = 6;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        LCD_E = 1'b0;
   logic        LCD_RS = 1'b0;
   logic        LCD_RW = 1'b0;
   logic [7:0]  LCD_DATA = 8'h00;
   logic [4:0]  rd_addr = 5'd0;
   logic [7:0]  rd_data;
   logic [6:0]  cursor;
   logic        busy;
   logic        disp_on;
   logic        inc_mode;
   logic [15:0] xfer_count;
   logic [2:0]  err;

   lcd_bus_monitor #(.CLEAR_CYCLES(2000), .CMD_CYCLES(40)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .LCD_E      (LCD_E),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_DATA   (LCD_DATA),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .cursor     (cursor),
      .busy       (busy),
      .disp_on    (disp_on),
      .inc_mode   (inc_mode),
      .xfer_count (xfer_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic rd_req = 1'b0;
   logic rd_pend = 1'b0;
   logic st_req = 1'b0;

   function automatic logic [15:0] peek(input int sel);
      case (sel)
         SEL_RD:   return {8'h00, rd_data};
         SEL_CUR:  return {9'h000, cursor};
         SEL_DISP: return {15'h0000, disp_on};
         SEL_INC:  return {15'h0000, inc_mode};
         SEL_XFER: return xfer_count;
         SEL_ERR:  return {13'h0000, err};
         default:  return {15'h0000, busy};
      endcase
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_underflow: got output event, expected none queued");
      end else begin
         e = sb_q.pop_front();
         cmp(e.name, peek(e.sel), e.exp);
      end
   endtask

   // Monitor: a read presented last cycle or a status request this cycle
   // is an output event; pop the oldest expectation and compare.
   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      if (rd_pend) pop_cmp();
      if (st_req)  pop_cmp();
   end

   task automatic push(input int sel, input logic [15:0] exp, input string name);
      exp_t e;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic chk(input int sel, input logic [15:0] exp, input string name);
      @(posedge clk); #1;
      push(sel, exp, name);
      st_req = 1'b1;
      @(posedge clk); #1;
      st_req = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
      @(posedge clk); #1;
      push(SEL_RD, {8'h00, exp}, name);
      rd_addr = a;
      rd_req  = 1'b1;
      @(posedge clk); #1;
      rd_req  = 1'b0;
   endtask

   // One E pulse; optionally present a read in the E-fall (transaction) cycle.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d,
                         input logic do_rd, input logic [4:0] ra,
                         input logic [7:0] rexp, input string rname);
      @(posedge clk); #1;
      LCD_E = 1'b1; LCD_RS = rs; LCD_RW = rw; LCD_DATA = d;
      @(posedge clk); #1;
      LCD_E = 1'b0;
      if (do_rd) begin
         push(SEL_RD, {8'h00, rexp}, rname);
         rd_addr = ra;
         rd_req  = 1'b1;
      end
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   // Counts busy cycles until it falls; a bounded wait.
   task automatic wait_idle(output int len);
      len = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         len++;
         if (len > 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy after %0d cycles, expected release", len);
            break;
         end
      end
   endtask

   task automatic put(input logic rs, input logic [7:0] d);
      int len;
      strobe(rs, 1'b0, d, 1'b0, 5'd0, 8'h00, "");
      wait_idle(len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      int len;
      logic [7:0] clk_txt [8];
      clk_txt = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};

      // Reset values while held in reset.
      repeat (2) @(posedge clk);
      chk(SEL_RD,   16'h0000, "rst_rd_data");
      chk(SEL_CUR,  16'h0000, "rst_cursor");
      chk(SEL_BUSY, 16'h0000, "rst_busy");
      chk(SEL_DISP, 16'h0000, "rst_disp_on");
      chk(SEL_INC,  16'h0001, "rst_inc_mode");
      chk(SEL_XFER, 16'h0000, "rst_xfer");
      chk(SEL_ERR,  16'h0000, "rst_err");
      @(posedge clk); #1;
      resetn = 1'b1;

      // Init sequence.
      strobe(1'b0, 1'b0, 8'h38, 1'b0, 5'd0, 8'h00, "");
      wait_idle(len);
      cmp("cmd_busy_len", 16'(len), 16'd40);
      put(1'b0, 8'h0C);
      strobe(1'b0, 1'b0, 8'h01, 1'b0, 5'd0, 8'h00, "");
      wait_idle(len);
      cmp("clear_busy_len", 16'(len), 16'd2000);
      chk(SEL_DISP, 16'h0001, "init_disp_on");
      chk(SEL_CUR,  16'h0000, "init_cursor");
      chk(SEL_XFER, 16'd3,    "init_xfer");
      chk(SEL_ERR,  16'h0000, "init_err");
      for (int i = 0; i < 32; i++) rd(5'(i), 8'h20, "clear_fill");

      // Clock text on row 1.
      put(1'b0, 8'hC0);
      for (int i = 0; i < 8; i++) put(1'b1, clk_txt[i]);
      chk(SEL_CUR, 16'h0048, "row1_text_cursor");
      for (int i = 0; i < 8; i++) rd(5'(16 + i), clk_txt[i], "row1_text");

      // Line-end wrap, then decrement across the row-1 start.
      put(1'b0, 8'hA7);
      put(1'b1, 8'h58);
      chk(SEL_CUR, 16'h0040, "wrap_0x27_cursor");
      rd(5'd7, 8'h20, "wrap_0x27_nostore");
      put(1'b0, 8'h04);
      chk(SEL_INC, 16'h0000, "entry_dec");
      put(1'b1, 8'h59);
      chk(SEL_CUR, 16'h0027, "dec_0x40_cursor");
      rd(5'd16, 8'h59, "dec_store_r1c0");
      rd(5'd17, 8'h32, "dec_r1c1_kept");
      put(1'b0, 8'h06);
      chk(SEL_XFER, 16'd17, "xfer_after_wrap");

      // Strobe while busy is dropped; read strobe flagged.
      put(1'b0, 8'h85);
      strobe(1'b1, 1'b0, 8'h5A, 1'b0, 5'd0, 8'h00, "");
      repeat (2) @(posedge clk);
      strobe(1'b1, 1'b0, 8'h57, 1'b0, 5'd0, 8'h00, "");
      chk(SEL_ERR,  16'h0001, "busy_err");
      chk(SEL_XFER, 16'd19,   "busy_xfer_held");
      wait_idle(len);
      chk(SEL_CUR, 16'h0006, "busy_cursor_held");
      rd(5'd5, 8'h5A, "busy_first_stored");
      rd(5'd6, 8'h20, "busy_drop_nostore");
      strobe(1'b0, 1'b1, 8'h00, 1'b0, 5'd0, 8'h00, "");
      chk(SEL_ERR,  16'h0003, "read_err");
      chk(SEL_BUSY, 16'h0000, "read_no_busy");
      put(1'b0, 8'h28);
      chk(SEL_ERR,  16'h0007, "dl_err");
      chk(SEL_XFER, 16'd20,   "dl_xfer");

      // Reset in the middle of a fill.
      strobe(1'b0, 1'b0, 8'h01, 1'b0, 5'd0, 8'h00, "");
      repeat (10) @(posedge clk);
      chk(SEL_BUSY, 16'h0001, "fill_busy");
      @(posedge clk); #1;
      resetn = 1'b0;
      push(SEL_RD, 16'h0000, "midfill_rd_data");
      st_req = 1'b1;
      @(posedge clk); #1;
      st_req = 1'b0;
      resetn = 1'b1;
      chk(SEL_BUSY, 16'h0000, "midfill_busy");
      chk(SEL_DISP, 16'h0000, "midfill_disp_on");
      chk(SEL_XFER, 16'h0000, "midfill_xfer");
      chk(SEL_ERR,  16'h0000, "midfill_err");
      chk(SEL_INC,  16'h0001, "midfill_inc");
      chk(SEL_CUR,  16'h0000, "midfill_cursor");

      // Row 0 text and back-to-back readback.
      put(1'b0, 8'h80);
      for (int i = 0; i < 16; i++) put(1'b1, 8'(8'h41 + i));
      chk(SEL_CUR, 16'h0010, "row0_cursor");
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         push(SEL_RD, {8'h00, 8'(8'h41 + i)}, "row0_burst");
         rd_addr = 5'(i);
         rd_req  = 1'b1;
      end
      @(posedge clk); #1;
      rd_req = 1'b0;

      // Same-cycle write and read of one location.
      put(1'b0, 8'h83);
      strobe(1'b1, 1'b0, 8'h71, 1'b1, 5'd3, 8'h44, "rw_same_old");
      wait_idle(len);
      rd(5'd3, 8'h71, "rw_same_new");
      chk(SEL_XFER, 16'd19, "final_xfer");
      chk(SEL_ERR,  16'h0000, "final_err");

      repeat (3) @(posedge clk);
      cmp("scoreboard_drained", 16'(sb_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
